pipelined_carry_adder: RTL and testbench

PIPELINED_CARRY_ADDER -- requirements
Module: pipelined_carry_adder

---
 rtl/pipelined_carry_adder.sv | 113 +++++++++++
 tb/tb_pipelined_carry_adder.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_carry_adder.sv
// Chunked adder/subtractor with one registered carry hop per stage.
// Define PCA_OVF_EN to add the signed-overflow output ovf.
module pipelined_carry_adder #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             out_valid,
    input  logic             out_ready
`ifdef PCA_OVF_EN
    ,
    output logic             ovf
`endif
);
    localparam int CHUNK = WIDTH / STAGES;
    localparam int LAST  = STAGES - 1;

    logic             adv;
    logic [WIDTH-1:0] bx;
    logic             c0;

    assign adv      = out_ready || !out_valid;
    assign in_ready = adv;

    // subtract runs as a + ~b + !cin so one carry chain serves both
    assign bx = sub ? ~b : b;
    assign c0 = sub ? ~cin : cin;

    for (genvar k = 0; k < STAGES; k++) begin : g_st
        logic [WIDTH-1:0] pa;
        logic [WIDTH-1:0] pb;
        logic [WIDTH-1:0] pr;
        logic [WIDTH-1:0] nr;
        logic [WIDTH-1:0] a_q;
        logic [WIDTH-1:0] b_q;
        logic [WIDTH-1:0] r_q;
        logic             pc;
        logic             pv;
        logic             cy_q;
        logic             vld_q;
        logic [CHUNK:0]   part;

        if (k == 0) begin : g_in
            assign pa = a;
            assign pb = bx;
            assign pr = '0;
            assign pc = c0;
            assign pv = in_valid;
        end else begin : g_fwd
            assign pa = g_st[k-1].a_q;
            assign pb = g_st[k-1].b_q;
            assign pr = g_st[k-1].r_q;
            assign pc = g_st[k-1].cy_q;
            assign pv = g_st[k-1].vld_q;
        end

        assign part = {1'b0, pa[k*CHUNK +: CHUNK]}
                    + {1'b0, pb[k*CHUNK +: CHUNK]}
                    + {{CHUNK{1'b0}}, pc};

        // finished low slices ride along with the operands
        always_comb begin
            nr = pr;
            nr[k*CHUNK +: CHUNK] = part[CHUNK-1:0];
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                vld_q <= 1'b0;
                cy_q  <= 1'b0;
                a_q   <= '0;
                b_q   <= '0;
                r_q   <= '0;
            end else if (adv) begin
                vld_q <= pv;
                cy_q  <= part[CHUNK];
                a_q   <= pa;
                b_q   <= pb;
                r_q   <= nr;
            end
        end
    end

    assign sum       = g_st[LAST].r_q;
    assign cout      = g_st[LAST].cy_q;
    assign out_valid = g_st[LAST].vld_q;

`ifdef PCA_OVF_EN
    logic ovf_q;

    // pb is already ~b for subtract, so one sign rule covers both
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (adv) begin
            ovf_q <= (g_st[LAST].pa[WIDTH-1] == g_st[LAST].pb[WIDTH-1])
                  && (g_st[LAST].part[CHUNK-1] != g_st[LAST].pa[WIDTH-1]);
        end
    end

    assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_pipelined_carry_adder.sv
// Directed bench for pipelined_carry_adder (WIDTH=16, STAGES=4).
// Checks ovf too when built with PCA_OVF_EN.
module tb_pipelined_carry_adder;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] sum;
    logic        cout;
    logic        out_valid;
    logic        out_ready;
`ifdef PCA_OVF_EN
    logic        ovf;
`endif

    always #5 clk = ~clk;

    pipelined_carry_adder #(
        .WIDTH (16),
        .STAGES(4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .sub      (sub),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .sum      (sum),
        .cout     (cout),
        .out_valid(out_valid),
        .out_ready(out_ready)
`ifdef PCA_OVF_EN
        ,
        .ovf      (ovf)
`endif
    );

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic        ci;
        logic        s;
        logic [17:0] e;
    } vec_t;

    int          errs = 0;
    int          nchk = 0;
    int          nres = 0;
    logic [17:0] expq[$];
    logic [17:0] e;
    vec_t        tv[12];

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        nchk++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // expected = {ovf, cout, sum}
    function automatic logic [17:0] model(input logic [15:0] x,
                                          input logic [15:0] y,
                                          input logic ci,
                                          input logic s);
        int unsigned r;
        logic [15:0] sm;
        logic        co;
        logic        o;
        if (!s) begin
            r  = 32'(x) + 32'(y) + 32'(ci);
            sm = r[15:0];
            co = r[16];
            o  = (x[15] == y[15]) && (sm[15] != x[15]);
        end else begin
            sm = x - y - 16'(ci);
            co = (32'(x) >= 32'(y) + 32'(ci));
            o  = (x[15] != y[15]) && (sm[15] != x[15]);
        end
        return {o, co, sm};
    endfunction

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (expq.size() == 0) begin
                check("stray_result", 32'd1, 32'd0);
            end else begin
                e = expq.pop_front();
                check("sum", 32'(sum), 32'(e[15:0]));
                check("cout", 32'(cout), 32'(e[16]));
`ifdef PCA_OVF_EN
                check("ovf", 32'(ovf), 32'(e[17]));
`endif
                nres++;
            end
        end
    end

    task automatic send(input logic [15:0] x, input logic [15:0] y,
                        input logic ci, input logic s,
                        input logic [17:0] exp, output int waits);
        logic acc;
        logic ok;
        ok    = 1'b0;
        waits = 0;
        a        = x;
        b        = y;
        cin      = ci;
        sub      = s;
        in_valid = 1'b1;
        for (int t = 0; t < 40 && !ok; t++) begin
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                expq.push_back(exp);
                ok = 1'b1;
            end else begin
                waits++;
            end
        end
        in_valid = 1'b0;
        if (!ok) check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1);
    end

    initial begin
        int          w;
        int          stalls;
        int          n0;
        int          stale;
        logic [15:0] hs;
        logic [15:0] x;
        logic [15:0] y;
        logic [7:0]  p;

        tv = '{
            '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 18'h10000},
            '{16'h0005, 16'h0007, 1'b0, 1'b1, 18'h0FFFE},
            '{16'h0007, 16'h0005, 1'b1, 1'b1, 18'h10001},
            '{16'h1234, 16'h4321, 1'b1, 1'b0, 18'h05556},
            '{16'h8000, 16'h8000, 1'b0, 1'b0, 18'h30000},
            '{16'h00FF, 16'h0F01, 1'b0, 1'b0, 18'h01000},
            '{16'h0000, 16'h0000, 1'b0, 1'b1, 18'h10000},
            '{16'h0000, 16'h0000, 1'b1, 1'b1, 18'h0FFFF},
            '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 18'h1FFFF},
            '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 18'h28000},
            '{16'h8000, 16'h0001, 1'b0, 1'b1, 18'h37FFF},
            '{16'h0001, 16'h0001, 1'b0, 1'b0, 18'h00002}
        };

        rst       = 1'b1;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        sub       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;

        // reset state
        idle(2);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        rst       = 1'b0;
        out_ready = 1'b1;
        idle(1);
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        // latency: accepted at edge A, visible after edge A+3
        send(16'hFFFF, 16'h0001, 1'b0, 1'b0, 18'h10000, w);
        idle(2);
        check("lat_early_valid", 32'(out_valid), 32'd0);
        idle(1);
        check("lat_valid", 32'(out_valid), 32'd1);
        check("lat_sum", 32'(sum), 32'h0000);
        check("lat_cout", 32'(cout), 32'd1);
        idle(2);

        // directed vectors, back to back
        n0 = nres;
        for (int i = 0; i < 12; i++) begin
            send(tv[i].a, tv[i].b, tv[i].ci, tv[i].s, tv[i].e, w);
        end
        idle(8);
        check("dir_count", 32'(nres - n0), 32'd12);

        // sweep of replicated nibble patterns at full rate
        n0     = nres;
        stalls = 0;
        for (int c = 0; c < 2; c++) begin
            for (int s = 0; s < 2; s++) begin
                for (int q = 0; q < 256; q++) begin
                    p = 8'(q);
                    x = {4{p[7:4]}};
                    y = {4{p[3:0]}};
                    send(x, y, c[0], s[0], model(x, y, c[0], s[0]), w);
                    stalls += w;
                end
            end
        end
        idle(8);
        check("sweep_stalls", 32'(stalls), 32'd0);
        check("sweep_count", 32'(nres - n0), 32'd1024);

        // backpressure: fill, stall 3 cycles, resume
        n0 = nres;
        for (int i = 0; i < 4; i++) begin
            send(tv[i+3].a, tv[i+3].b, tv[i+3].ci, tv[i+3].s, tv[i+3].e, w);
        end
        out_ready = 1'b0;
        check("fill_valid", 32'(out_valid), 32'd1);
        hs = sum;
        for (int i = 0; i < 3; i++) begin
            idle(1);
            check("stall_in_ready", 32'(in_ready), 32'd0);
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_sum", 32'(sum), 32'(hs));
        end
        out_ready = 1'b1;
        idle(10);
        check("stall_count", 32'(nres - n0), 32'd4);
        check("stall_queue", 32'(expq.size()), 32'd0);

        // reset with sets in flight
        for (int i = 0; i < 4; i++) begin
            send(tv[i].a, tv[i].b, tv[i].ci, tv[i].s, tv[i].e, w);
        end
        rst = 1'b1;
        idle(1);
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_sum", 32'(sum), 32'h0000);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        expq.delete();
        rst   = 1'b0;
        stale = 0;
        for (int i = 0; i < 10; i++) begin
            idle(1);
            if (out_valid) stale++;
        end
        check("midrst_stale", 32'(stale), 32'd0);
        check("final_queue", 32'(expq.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errs, nchk);
        $finish;
    end

endmodule
